// File: rtl/serializador.sv
// serializador: parallel-to-serial transmitter with a one-word holding buffer.
// Words enter over a valid/ack handshake and leave one bit per clock on
// data_out, qualified by write_out, with an optional idle gap between words.
//
// Handshake: the source raises data_valid_in with data_in and holds both
// until it sees ack_out. An ack_out pulse in a cycle means the word presented
// at the previous rising edge was captured, so the source must either drop
// data_valid_in or present its next word before the following edge. A word is
// captured when the buffer is empty, or when it is emptied into the shifter
// on that same edge, so the buffer refills without a lost cycle.
module serializador #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_100KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid_in,
    output logic             ack_out,
    output logic             data_out,
    output logic             write_out,
    output logic             status_out
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // state is kept as a named enum so checkers can observe the FSM directly
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] buffer;
    logic             buf_full;
    logic             buf_full_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    logic             word_done;
    logic             gap_done;
    logic             load;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] buf_rest;
    logic [WIDTH-1:0] shift_rest;

    // Next-state, load/accept decisions and bit selection for the chosen order
    always_comb begin
        word_done     = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
        gap_done      = (state == ST_GAP) && (gap_cnt == GAP_LAST);
        load          = buf_full && ((state == ST_IDLE) || (word_done && (GAP == 0)) || gap_done);
        accept        = data_valid_in && (!buf_full || load);
        buf_full_next = accept || (buf_full && !load);

        if (MSB_FIRST) begin
            first_bit  = buffer[WIDTH-1];
            next_bit   = shift_reg[WIDTH-1];
            buf_rest   = {buffer[WIDTH-2:0], 1'b0};
            shift_rest = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin
            first_bit  = buffer[0];
            next_bit   = shift_reg[0];
            buf_rest   = {1'b0, buffer[WIDTH-1:1]};
            shift_rest = {1'b0, shift_reg[WIDTH-1:1]};
        end

        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (word_done) begin
                    if (GAP > 0)    state_next = ST_GAP;
                    else if (!load) state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_done) state_next = load ? ST_SHIFT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM, holding buffer, shifter and all registered outputs
    always_ff @(posedge clk_100KHz) begin
        if (!reset) begin
            state      <= ST_IDLE;
            buffer     <= '0;
            buf_full   <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ack_out    <= 1'b0;
            data_out   <= 1'b0;
            write_out  <= 1'b0;
            status_out <= 1'b0;
        end else begin
            state      <= state_next;
            buf_full   <= buf_full_next;
            ack_out    <= accept;
            status_out <= (state_next != ST_IDLE) || buf_full_next;

            if (accept) buffer <= data_in;

            if (load) begin
                shift_reg <= buf_rest;
                data_out  <= first_bit;
                bit_cnt   <= '0;
                write_out <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (word_done) begin
                            write_out <= 1'b0;
                            gap_cnt   <= '0;
                        end else begin
                            data_out  <= next_bit;
                            shift_reg <= shift_rest;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serializador.sv
// Testbench for serializador: dut0 uses GAP=1/MSB first, dut1 GAP=0/LSB first.
module tb_serializador;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [W-1:0] din0, din1;
  logic val0, val1;
  logic ack0, dout0, wr0, st0;
  logic ack1, dout1, wr1, st1;

  serializador #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1)) dut0 (
    .clk_100KHz(clk), .reset(rst_n), .data_in(din0), .data_valid_in(val0),
    .ack_out(ack0), .data_out(dout0), .write_out(wr0), .status_out(st0)
  );

  serializador #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) dut1 (
    .clk_100KHz(clk), .reset(rst_n), .data_in(din1), .data_valid_in(val1),
    .ack_out(ack1), .data_out(dout1), .write_out(wr1), .status_out(st1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel_g = 0;
  logic ack_m, wr_m, dout_m, st_m;
  assign ack_m  = (sel_g == 1) ? ack1  : ack0;
  assign wr_m   = (sel_g == 1) ? wr1   : wr0;
  assign dout_m = (sel_g == 1) ? dout1 : dout0;
  assign st_m   = (sel_g == 1) ? st1   : st0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  logic [0:0] e0, e1;
  int runs0[$], runs1[$], gaps0[$], gaps1[$];
  int run0 = 0, idle0 = 0, run1 = 0, idle1 = 0;
  bit seen0 = 1'b0, seen1 = 1'b0;

  task automatic push_exp(input int sel, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      if (sel == 0) exp_q0.push_back(w[7-i]);
      else          exp_q1.push_back(w[i]);
    end
  endtask

  task automatic clear_mon();
    runs0.delete(); gaps0.delete(); seen0 = 1'b0; idle0 = 0;
    runs1.delete(); gaps1.delete(); seen1 = 1'b0; idle1 = 0;
  endtask

  always @(negedge clk) begin
    if (wr0 === 1'b1) begin
      check("dut0 bit was expected", exp_q0.size() != 0, 1);
      if (exp_q0.size() != 0) begin
        e0 = exp_q0.pop_front();
        check("dut0 serial bit", dout0, e0);
      end
      if (run0 == 0 && seen0) gaps0.push_back(idle0);
      run0++;
      idle0 = 0;
    end else begin
      if (run0 > 0) begin runs0.push_back(run0); seen0 = 1'b1; run0 = 0; end
      idle0++;
    end
  end

  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      check("dut1 bit was expected", exp_q1.size() != 0, 1);
      if (exp_q1.size() != 0) begin
        e1 = exp_q1.pop_front();
        check("dut1 serial bit", dout1, e1);
      end
      if (run1 == 0 && seen1) gaps1.push_back(idle1);
      run1++;
      idle1 = 0;
    end else begin
      if (run1 > 0) begin runs1.push_back(run1); seen1 = 1'b1; run1 = 0; end
      idle1++;
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_w[$];
  int acks[$];
  logic ack_wr[$];

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin val0 = v; din0 = d; end
    else          begin val1 = v; din1 = d; end
  endtask

  // Present tx_w with valid held, advancing on each ack
  task automatic send_words(input int sel, input string name);
    int idx = 0;
    int n = 0;
    sel_g = sel;
    acks.delete();
    ack_wr.delete();
    @(negedge clk); #1;
    drive(sel, 1'b1, tx_w[0]);
    while (idx < tx_w.size() && n < 200) begin
      @(negedge clk);
      n++;
      if (ack_m) begin
        acks.push_back(cyc);
        ack_wr.push_back(wr_m);
        push_exp(sel, tx_w[idx]);
        idx++;
      end
      #1;
      if (idx < tx_w.size()) drive(sel, 1'b1, tx_w[idx]);
      else                   drive(sel, 1'b0, 8'h00);
    end
    check({name, " all words acked"}, idx, tx_w.size());
  endtask

  task automatic wait_idle(input int sel, input string name);
    int n = 0;
    sel_g = sel;
    @(negedge clk);
    while ((st_m || wr_m) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, " idle reached"}, (n < 100), 1);
    @(negedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [7:0] bits;   // serial order, leftmost bit leaves first
  } vec_t;

  vec_t vecs[7];
  logic a1, w1, a2, fw;
  logic [7:0] got;
  int n, lag;

  initial begin
    vecs[0] = '{0, 8'hA5, 8'b1010_0101};
    vecs[1] = '{1, 8'h81, 8'b1000_0001};
    vecs[2] = '{0, 8'h3C, 8'b0011_1100};
    vecs[3] = '{1, 8'h06, 8'b0110_0000};
    vecs[4] = '{0, 8'h01, 8'b0000_0001};
    vecs[5] = '{1, 8'hF0, 8'b0000_1111};
    vecs[6] = '{1, 8'h12, 8'b0100_1000};

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("rst dut0 ack", ack0, 0);
    check("rst dut0 data", dout0, 0);
    check("rst dut0 write", wr0, 0);
    check("rst dut0 status", st0, 0);
    check("rst dut1 ack", ack1, 0);
    check("rst dut1 data", dout1, 0);
    check("rst dut1 write", wr1, 0);
    check("rst dut1 status", st1, 0);
    #1 rst_n = 1'b1;
    clear_mon();

    // single words, valid for one cycle
    for (int i = 0; i < 7; i++) begin
      sel_g = vecs[i].sel;
      @(negedge clk); #1;
      drive(vecs[i].sel, 1'b1, vecs[i].word);
      @(negedge clk);
      a1 = ack_m; w1 = wr_m;
      if (a1) push_exp(vecs[i].sel, vecs[i].word);
      #1 drive(vecs[i].sel, 1'b0, 8'h00);
      @(negedge clk);
      a2 = ack_m; fw = wr_m;
      got = '0; n = 0;
      while (wr_m && n < 20) begin
        got = {got[6:0], dout_m};
        n++;
        @(negedge clk);
      end
      lag = 0;
      while (st_m && lag < 10) begin
        lag++;
        @(negedge clk);
      end
      check("vec ack latency", a1, 1);
      check("vec no early write", w1, 0);
      check("vec ack width", a2, 0);
      check("vec first bit start", fw, 1);
      check("vec bit count", n, 8);
      check("vec serial word", got, vecs[i].bits);
      check("vec status lag", lag, (vecs[i].sel == 0) ? 1 : 0);
    end
    #1;
    check("vec dut0 queue drained", exp_q0.size(), 0);
    check("vec dut1 queue drained", exp_q1.size(), 0);

    // two words back to back with one idle cycle between them
    clear_mon();
    tx_w = '{8'h3C, 8'hC3};
    send_words(0, "t3");
    wait_idle(0, "t3");
    check("t3 ack count", acks.size(), 2);
    check("t3 second ack during first word", (ack_wr.size() > 1) ? ack_wr[1] : 1'b0, 1);
    check("t3 run count", runs0.size(), 2);
    check("t3 run0 length", (runs0.size() > 0) ? runs0[0] : -1, 8);
    check("t3 run1 length", (runs0.size() > 1) ? runs0[1] : -1, 8);
    check("t3 gap count", gaps0.size(), 1);
    check("t3 gap length", (gaps0.size() > 0) ? gaps0[0] : -1, 1);
    check("t3 queue drained", exp_q0.size(), 0);

    // three words with no gap: continuous stream
    clear_mon();
    tx_w = '{8'h11, 8'h22, 8'h33};
    send_words(1, "t4");
    wait_idle(1, "t4");
    check("t4 ack count", acks.size(), 3);
    check("t4 third ack spacing", (acks.size() > 2) ? (acks[2] - acks[1]) : -1, 8);
    check("t4 run count", runs1.size(), 1);
    check("t4 run length", (runs1.size() > 0) ? runs1[0] : -1, 24);
    check("t4 gap count", gaps1.size(), 0);
    check("t4 queue drained", exp_q1.size(), 0);

    // reset in the middle of a word with another word buffered
    clear_mon();
    tx_w = '{8'hFF, 8'h00};
    send_words(0, "t5");
    n = 0;
    while (run0 < 5 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5 reached bit 4", run0, 5);
    rst_n = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    check("t5 write after reset", wr0, 0);
    check("t5 status after reset", st0, 0);
    check("t5 ack after reset", ack0, 0);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    #1;
    check("t5 nothing sent after reset", runs0.size() + run0, 0);
    tx_w = '{8'h5A};
    send_words(0, "t5 recover");
    wait_idle(0, "t5 recover");
    check("t5 recover run count", runs0.size(), 1);
    check("t5 recover run length", (runs0.size() > 0) ? runs0[0] : -1, 8);
    check("t5 queue drained", exp_q0.size(), 0);

    // valid arrives the cycle the last bit of a word leaves
    clear_mon();
    tx_w = '{8'hC5};
    send_words(1, "t6");
    n = 0;
    while (run1 < 8 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6 reached last bit", run1, 8);
    drive(1, 1'b1, 8'h3A);
    @(negedge clk);
    a1 = ack1; w1 = wr1;
    if (a1) push_exp(1, 8'h3A);
    #1 drive(1, 1'b0, 8'h00);
    wait_idle(1, "t6");
    check("t6 ack", a1, 1);
    check("t6 idle after last bit", w1, 0);
    check("t6 run count", runs1.size(), 2);
    check("t6 run0 length", (runs1.size() > 0) ? runs1[0] : -1, 8);
    check("t6 run1 length", (runs1.size() > 1) ? runs1[1] : -1, 8);
    check("t6 gap length", (gaps1.size() > 0) ? gaps1[0] : -1, 1);
    check("t6 queue drained", exp_q1.size(), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
